// File: rtl/f_pkg.sv
// Shared types and constants for the F (single-precision) arithmetic unit.
package f_pkg;

  localparam int unsigned QBITS  = 25;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned FLAG_W = 5;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } round_mode_e;

  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;
  localparam logic [30:0] INF_MAG    = 31'h7F80_0000;

  typedef enum logic [2:0] {
    DS_IDLE  = 3'd0,
    DS_SPEC  = 3'd1,
    DS_ALIGN = 3'd2,
    DS_CALC  = 3'd3,
    DS_ROUND = 3'd4
  } div_state_e;

  // Operand class; zero includes subnormals (denormals-are-zero).
  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;
  } fclass_t;

endpackage

// File: rtl/F_isNaN.sv
// Operand classifier: NaN / signaling NaN / infinity / zero (subnormals count as zero).
module F_isNaN
  import f_pkg::*;
(
  input  logic [31:0] x,
  output fclass_t     cls
);

  logic exp_ones;
  logic exp_zero;
  logic frac_nz;

  assign exp_ones = &x[30:23];
  assign exp_zero = ~|x[30:23];
  assign frac_nz  = |x[22:0];

  assign cls.nan  = exp_ones & frac_nz;
  assign cls.snan = exp_ones & frac_nz & ~x[22];
  assign cls.inf  = exp_ones & ~frac_nz;
  assign cls.zero = exp_zero;

endmodule

// File: rtl/f_round_unit.sv
// Round-increment decision shared by the F divider and multiplier.
module f_round_unit
  import f_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic [2:0] mode,
  output logic       incr
);

  logic inexact;

  assign inexact = guard | sticky;

  // Unlisted encodings fall back to round-to-nearest-even.
  always_comb begin
    incr = guard & (sticky | lsb);
    case (mode)
      RM_RTZ:  incr = 1'b0;
      RM_RDN:  incr = sign & inexact;
      RM_RUP:  incr = ~sign & inexact;
      RM_RMM:  incr = guard;
      default: incr = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/f_div_seq.sv
// Iterative single-precision divider: radix-2 restoring, one quotient bit per cycle.
module f_div_seq
  import f_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rounding,
  output logic        busy,
  output logic        done,
  output logic [4:0]  flags,
  output logic [31:0] y
);

  localparam logic [2:0] ST_IDLE  = DS_IDLE;
  localparam logic [2:0] ST_SPEC  = DS_SPEC;
  localparam logic [2:0] ST_ALIGN = DS_ALIGN;
  localparam logic [2:0] ST_CALC  = DS_CALC;
  localparam logic [2:0] ST_ROUND = DS_ROUND;

  logic [2:0]              state, state_n;
  logic                    sign_q, sign_n;
  logic [2:0]              rm_q, rm_n;
  logic [7:0]              ea_q, ea_n, eb_q, eb_n;
  logic signed [EXP_W-1:0] exp_q, exp_n;
  logic [MANT_W+1:0]       rem_q, rem_n;
  logic [MANT_W-1:0]       div_q, div_n;
  logic [QBITS-1:0]        quo_q, quo_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  fclass_t                 ca_q, ca_n, cb_q, cb_n;
  fclass_t                 ca_c, cb_c;
  logic                    busy_n, done_n;
  logic [4:0]              flags_n;
  logic [31:0]             y_n;

  F_isNaN u_cls_a (.x(a), .cls(ca_c));
  F_isNaN u_cls_b (.x(b), .cls(cb_c));

  // Trial subtraction for the restoring step.
  logic [MANT_W+2:0] diff;
  assign diff = {1'b0, rem_q} - (MANT_W+3)'(div_q);

  // Exponent before the quotient normalisation check.
  logic signed [EXP_W-1:0] exp_al;
  assign exp_al = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;

  // Rounding of the 24-bit quotient with guard and remainder sticky.
  logic                    sticky, inexact, incr, carry, ovf, unf, to_max;
  logic [MANT_W:0]         mant_r;
  logic [22:0]             frac_r;
  logic signed [EXP_W-1:0] exp_r;

  assign sticky  = |rem_q;
  assign inexact = quo_q[0] | sticky;

  f_round_unit u_round (
    .sign  (sign_q),
    .lsb   (quo_q[1]),
    .guard (quo_q[0]),
    .sticky(sticky),
    .mode  (rm_q),
    .incr  (incr)
  );

  assign mant_r = {1'b0, quo_q[QBITS-1:1]} + (MANT_W+1)'(incr);
  assign carry  = mant_r[MANT_W];
  assign frac_r = carry ? 23'd0 : mant_r[22:0];
  assign exp_r  = exp_q + $signed({{(EXP_W-1){1'b0}}, carry});
  assign ovf    = (exp_r >= 10'sd255);
  assign unf    = (exp_r <= 10'sd0);
  assign to_max = (rm_q == RM_RTZ) | ((rm_q == RM_RDN) & ~sign_q) | ((rm_q == RM_RUP) & sign_q);

  // Special-operand result.
  logic [31:0] spec_y;
  logic [4:0]  spec_flags;

  always_comb begin
    spec_y     = {sign_q, 31'd0};
    spec_flags = 5'd0;
    if (ca_q.nan | cb_q.nan) begin
      spec_y             = CANON_NAN;
      spec_flags[FLG_NV] = ca_q.snan | cb_q.snan;
    end else if ((ca_q.zero & cb_q.zero) | (ca_q.inf & cb_q.inf)) begin
      spec_y             = CANON_NAN;
      spec_flags[FLG_NV] = 1'b1;
    end else if (ca_q.inf) begin
      spec_y = {sign_q, INF_MAG};
    end else if (cb_q.zero) begin
      spec_y             = {sign_q, INF_MAG};
      spec_flags[FLG_DZ] = 1'b1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    sign_n  = sign_q;
    rm_n    = rm_q;
    ea_n    = ea_q;
    eb_n    = eb_q;
    exp_n   = exp_q;
    rem_n   = rem_q;
    div_n   = div_q;
    quo_n   = quo_q;
    cnt_n   = cnt_q;
    ca_n    = ca_q;
    cb_n    = cb_q;
    done_n  = 1'b0;
    flags_n = flags;
    y_n     = y;

    case (state)
      ST_IDLE: begin
        if (start) begin
          sign_n = a[31] ^ b[31];
          rm_n   = rounding;
          ea_n   = a[30:23];
          eb_n   = b[30:23];
          rem_n  = {2'b00, 1'b1, a[22:0]};
          div_n  = {1'b1, b[22:0]};
          quo_n  = '0;
          cnt_n  = '0;
          ca_n   = ca_c;
          cb_n   = cb_c;
          if (ca_c.nan | ca_c.inf | ca_c.zero | cb_c.nan | cb_c.inf | cb_c.zero)
            state_n = ST_SPEC;
          else
            state_n = ST_ALIGN;
        end
      end
      ST_SPEC: begin
        y_n     = spec_y;
        flags_n = spec_flags;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      ST_ALIGN: begin
        // Pre-shift a smaller dividend so the quotient lands in [1,2).
        if (rem_q < (MANT_W+2)'(div_q)) begin
          rem_n = {rem_q[MANT_W:0], 1'b0};
          exp_n = exp_al - 10'sd1;
        end else begin
          exp_n = exp_al;
        end
        cnt_n   = '0;
        state_n = ST_CALC;
      end
      ST_CALC: begin
        if (!diff[MANT_W+2]) begin
          rem_n = {diff[MANT_W:0], 1'b0};
          quo_n = {quo_q[QBITS-2:0], 1'b1};
        end else begin
          rem_n = {rem_q[MANT_W:0], 1'b0};
          quo_n = {quo_q[QBITS-2:0], 1'b0};
        end
        cnt_n = cnt_q + 5'd1;
        if (cnt_q == CNT_W'(QBITS - 1))
          state_n = ST_ROUND;
      end
      ST_ROUND: begin
        flags_n = 5'd0;
        flags_n[FLG_NX] = inexact;
        if (ovf) begin
          y_n = to_max ? {sign_q, MAX_FINITE} : {sign_q, INF_MAG};
          flags_n[FLG_OF] = 1'b1;
          flags_n[FLG_NX] = 1'b1;
        end else if (unf) begin
          y_n = {sign_q, 31'd0};
          flags_n[FLG_UF] = 1'b1;
          flags_n[FLG_NX] = 1'b1;
        end else begin
          y_n = {sign_q, exp_r[7:0], frac_r};
        end
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      sign_q <= 1'b0;
      rm_q   <= 3'd0;
      ea_q   <= 8'd0;
      eb_q   <= 8'd0;
      exp_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      ca_q   <= '0;
      cb_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      flags  <= 5'd0;
      y      <= 32'd0;
    end else begin
      state  <= state_n;
      sign_q <= sign_n;
      rm_q   <= rm_n;
      ea_q   <= ea_n;
      eb_q   <= eb_n;
      exp_q  <= exp_n;
      rem_q  <= rem_n;
      div_q  <= div_n;
      quo_q  <= quo_n;
      cnt_q  <= cnt_n;
      ca_q   <= ca_n;
      cb_q   <= cb_n;
      busy   <= busy_n;
      done   <= done_n;
      flags  <= flags_n;
      y      <= y_n;
    end
  end

endmodule

// File: tb/tb_f_div_seq.sv
// Directed bench for f_div_seq: timing, rounding, specials, range limits, handshake.
module tb_f_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  rounding;
  logic        busy;
  logic        done;
  logic [4:0]  flags;
  logic [31:0] y;

  int n_checks;
  int n_errors;

  f_div_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .rounding(rounding),
    .busy    (busy),
    .done    (done),
    .flags   (flags),
    .y       (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a divide in the current cycle and wait (bounded) for done.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] rm, input int exp_lat,
                        input logic [31:0] exp_y, input logic [4:0] exp_flags);
    int cyc;
    a = av; b = bv; rounding = rm; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_y"}, y, exp_y);
    check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; rounding = 3'b000;
    #1;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    step();

    // 6/2 with full busy/done timeline.
    a = 32'h40C0_0000; b = 32'h4000_0000; rounding = 3'b000; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      check($sformatf("t62_busy_c%0d", c), 32'(busy), 32'((c <= 27) ? 1 : 0));
      check($sformatf("t62_done_c%0d", c), 32'(done), 32'((c == 28) ? 1 : 0));
      if (c < 28) step();
    end
    check("t62_y", y, 32'h4040_0000);
    check("t62_flags", 32'(flags), 32'd0);

    // Start in the done cycle is accepted.
    run_op("third_rne", 32'h3F80_0000, 32'h4040_0000, 3'b000, 28, 32'h3EAA_AAAB, 5'b00001);
    step();
    check("done_pulse", 32'(done), 32'd0);
    run_op("third_rtz", 32'h3F80_0000, 32'h4040_0000, 3'b001, 28, 32'h3EAA_AAAA, 5'b00001);

    run_op("div_zero", 32'h3F80_0000, 32'h0000_0000, 3'b000, 2, 32'h7F80_0000, 5'b01000);
    run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 3'b000, 2, 32'h7FC0_0000, 5'b10000);
    run_op("snan", 32'h7F80_0001, 32'h3F80_0000, 3'b000, 2, 32'h7FC0_0000, 5'b10000);
    run_op("qnan", 32'h7FC0_0000, 32'h3F80_0000, 3'b000, 2, 32'h7FC0_0000, 5'b00000);
    run_op("inf_fin", 32'hFF80_0000, 32'h3F80_0000, 3'b000, 2, 32'hFF80_0000, 5'b00000);
    run_op("fin_inf", 32'h3F80_0000, 32'hFF80_0000, 3'b000, 2, 32'h8000_0000, 5'b00000);
    run_op("daz", 32'h0000_0001, 32'h3F80_0000, 3'b000, 2, 32'h0000_0000, 5'b00000);

    run_op("ovf_rne", 32'h7F7F_FFFF, 32'h3F00_0000, 3'b000, 28, 32'h7F80_0000, 5'b00101);
    run_op("ovf_rtz", 32'h7F7F_FFFF, 32'h3F00_0000, 3'b001, 28, 32'h7F7F_FFFF, 5'b00101);
    run_op("ovf_rdn_neg", 32'hFF7F_FFFF, 32'h3F00_0000, 3'b010, 28, 32'hFF80_0000, 5'b00101);
    run_op("unf", 32'h0080_0000, 32'h4000_0000, 3'b000, 28, 32'h0000_0000, 5'b00011);
    run_op("neg_rup", 32'hBF80_0000, 32'h4040_0000, 3'b011, 28, 32'hBEAA_AAAA, 5'b00001);
    run_op("pos_rup", 32'h3F80_0000, 32'h4040_0000, 3'b011, 28, 32'h3EAA_AAAB, 5'b00001);

    // Start while busy (cycles 5-10, other operands) is ignored.
    step();
    a = 32'h3F80_0000; b = 32'h4040_0000; rounding = 3'b001; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin step(); cyc++; end
    a = 32'h40C0_0000; b = 32'h4000_0000; rounding = 3'b000;
    while (cyc <= 10) begin start = 1'b1; step(); cyc++; end
    start = 1'b0;
    while (!done && cyc < 40) begin step(); cyc++; end
    check("busy_start_lat", 32'(cyc), 32'd28);
    check("busy_start_y", y, 32'h3EAA_AAAA);
    step();
    check("held_y", y, 32'h3EAA_AAAA);
    check("held_flags", 32'(flags), 32'd1);
    check("held_busy", 32'(busy), 32'd0);

    // Reset in cycle 12 aborts the divide.
    a = 32'h40C0_0000; b = 32'h4000_0000; rounding = 3'b000; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 12) begin step(); cyc++; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_y", y, 32'd0);
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("abort_nodone_%0d", c), 32'(done), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
